// File: rtl/apu_frame_sequencer.sv
// APU frame sequencer: divides CPU-rate enables into quarter/half-frame strobes
// and the 4-step frame IRQ, reprogrammed by $4017 writes after a short delay.
module apu_frame_sequencer #(
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned STEP1    = 7457,
    parameter int unsigned STEP2    = 14913,
    parameter int unsigned STEP3    = 22371,
    parameter int unsigned STEP4    = 29829,
    parameter int unsigned STEP5    = 37281,
    parameter int unsigned WR_DELAY = 3
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic             cpu_ce,
    input  logic             wr_en,
    input  logic [1:0]       wr_data,
    input  logic             irq_ack,
    output logic             quarter_frame,
    output logic             half_frame,
    output logic             frame_irq,
    output logic             mode,
    output logic [CNT_W-1:0] cycle_cnt
);

    localparam int unsigned DLY_W = (WR_DELAY < 2) ? 1 : $clog2(WR_DELAY + 1);

    typedef enum logic {
        RUN,
        WR_PEND
    } state_t;

    state_t           state;
    logic             inhibit;
    logic [DLY_W-1:0] dly;

    logic [CNT_W-1:0] wrap_c;
    logic             quarter_c;
    logic             half_c;
    logic             irq_set_c;
    logic             restart_c;

    // Event decode from the current count under the current (pre-write) mode
    always_comb begin
        quarter_c = 1'b0;
        half_c    = 1'b0;
        irq_set_c = 1'b0;
        wrap_c    = mode ? CNT_W'(STEP5 + 1) : CNT_W'(STEP4 + 1);
        restart_c = cpu_ce && !wr_en && (state == WR_PEND) && (dly == DLY_W'(1));

        if (cycle_cnt == CNT_W'(STEP1) || cycle_cnt == CNT_W'(STEP3)) begin
            quarter_c = 1'b1;
        end
        if (cycle_cnt == CNT_W'(STEP2)) begin
            quarter_c = 1'b1;
            half_c    = 1'b1;
        end
        if (!mode && cycle_cnt == CNT_W'(STEP4)) begin
            quarter_c = 1'b1;
            half_c    = 1'b1;
        end
        if (mode && cycle_cnt == CNT_W'(STEP5)) begin
            quarter_c = 1'b1;
            half_c    = 1'b1;
        end
        if (!mode && !inhibit &&
            cycle_cnt >= CNT_W'(STEP4 - 1) && cycle_cnt <= CNT_W'(STEP4 + 1)) begin
            irq_set_c = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            state         <= RUN;
            cycle_cnt     <= '0;
            mode          <= 1'b0;
            inhibit       <= 1'b0;
            dly           <= '0;
            frame_irq     <= 1'b0;
            quarter_frame <= 1'b0;
            half_frame    <= 1'b0;
        end else begin
            quarter_frame <= 1'b0;
            half_frame    <= 1'b0;

            if (cpu_ce) begin
                if (restart_c) begin
                    // Restart replaces this enable's increment and decoded event
                    cycle_cnt     <= '0;
                    state         <= RUN;
                    quarter_frame <= mode;
                    half_frame    <= mode;
                end else begin
                    quarter_frame <= quarter_c;
                    half_frame    <= half_c;
                    cycle_cnt     <= (cycle_cnt == wrap_c) ? '0 : cycle_cnt + CNT_W'(1);
                    if (state == WR_PEND && !wr_en) begin
                        dly <= dly - DLY_W'(1);
                    end
                end
            end

            if (wr_en) begin
                mode    <= wr_data[1];
                inhibit <= wr_data[0];
                dly     <= DLY_W'(WR_DELAY);
                state   <= WR_PEND;
            end

            // Set has priority over acknowledge / inhibit-write clear
            if (cpu_ce && !restart_c && irq_set_c) begin
                frame_irq <= 1'b1;
            end else if (irq_ack || (wr_en && wr_data[0])) begin
                frame_irq <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_apu_frame_sequencer.sv
// Scoreboard bench for apu_frame_sequencer: expected strobes are queued by the
// stimulus thread and popped by a negedge monitor; level outputs checked inline.
module tb_apu_frame_sequencer;

    localparam int unsigned CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_l;
    logic             cpu_ce;
    logic             wr_en;
    logic [1:0]       wr_data;
    logic             irq_ack;
    logic             quarter_frame;
    logic             half_frame;
    logic             frame_irq;
    logic             mode;
    logic [CNT_W-1:0] cycle_cnt;

    typedef struct packed {
        logic             q;
        logic             h;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    logic prev_strobe = 1'b0;

    always #5 clk = ~clk;

    apu_frame_sequencer dut (
        .clk           (clk),
        .rst_l         (rst_l),
        .cpu_ce        (cpu_ce),
        .wr_en         (wr_en),
        .wr_data       (wr_data),
        .irq_ack       (irq_ack),
        .quarter_frame (quarter_frame),
        .half_frame    (half_frame),
        .frame_irq     (frame_irq),
        .mode          (mode),
        .cycle_cnt     (cycle_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void push(input logic q, input logic h, input int unsigned cnt);
        exp_t e;
        e.q   = q;
        e.h   = h;
        e.cnt = CNT_W'(cnt);
        sb_q.push_back(e);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cnt(input int unsigned v);
        for (int i = 0; i < 40000; i++) begin
            if (cycle_cnt == CNT_W'(v)) return;
            tick();
        end
        checks++;
        errors++;
        $display("FAIL wait_cnt: timeout waiting for cnt %0d, got %0d", v, cycle_cnt);
    endtask

    task automatic ce_tick();
        cpu_ce = 1'b1;
        tick();
        cpu_ce = 1'b0;
        repeat (11) tick();
    endtask

    // Strobe monitor: every strobe must match the head of the expected queue
    always @(negedge clk) begin
        if (quarter_frame || half_frame) begin
            check("strobe_width", 32'(prev_strobe), 32'd0);
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: q=%0b h=%0b cnt=%0d, none expected",
                         quarter_frame, half_frame, cycle_cnt);
            end else begin
                mon_e = sb_q.pop_front();
                check("strobe_q",   32'(quarter_frame), 32'(mon_e.q));
                check("strobe_h",   32'(half_frame),    32'(mon_e.h));
                check("strobe_cnt", 32'(cycle_cnt),     32'(mon_e.cnt));
            end
        end
        prev_strobe = quarter_frame || half_frame;
    end

    initial begin
        rst_l   = 1'b0;
        cpu_ce  = 1'b0;
        wr_en   = 1'b0;
        wr_data = 2'b00;
        irq_ack = 1'b0;
        repeat (2) tick();
        check("reset_cnt",  32'(cycle_cnt),     32'd0);
        check("reset_mode", 32'(mode),          32'd0);
        check("reset_irq",  32'(frame_irq),     32'd0);
        check("reset_q",    32'(quarter_frame), 32'd0);
        check("reset_h",    32'(half_frame),    32'd0);
        rst_l = 1'b1;

        // 4-step frame from reset
        push(1'b1, 1'b0, 7458);
        push(1'b1, 1'b1, 14914);
        push(1'b1, 1'b0, 22372);
        push(1'b1, 1'b1, 29830);
        cpu_ce = 1'b1;
        wait_cnt(29828);
        check("irq_before_window", 32'(frame_irq), 32'd0);
        tick();
        check("irq_rise", 32'(frame_irq), 32'd1);

        // Ack without an enable clears; ack on a set enable loses to set
        cpu_ce  = 1'b0;
        irq_ack = 1'b1;
        tick();
        check("irq_ack_clear", 32'(frame_irq), 32'd0);
        check("ce_gate_ack",   32'(cycle_cnt), 32'd29829);
        cpu_ce = 1'b1;
        tick();
        check("irq_set_wins", 32'(frame_irq), 32'd1);
        check("cnt_29830",    32'(cycle_cnt), 32'd29830);

        // Inhibit write clears IRQ and blocks the last window count
        irq_ack = 1'b0;
        cpu_ce  = 1'b0;
        wr_en   = 1'b1;
        wr_data = 2'b01;
        tick();
        wr_en = 1'b0;
        check("wr_irq_clear", 32'(frame_irq), 32'd0);
        check("ce_gate_wr",   32'(cycle_cnt), 32'd29830);
        cpu_ce = 1'b1;
        tick();
        check("inhibit_window", 32'(frame_irq), 32'd0);
        check("wrap_mode0",     32'(cycle_cnt), 32'd0);
        tick();
        tick();
        check("restart_mode0_cnt", 32'(cycle_cnt), 32'd0);

        // Switch to 5-step
        wait_cnt(100);
        push(1'b1, 1'b1, 0);
        push(1'b1, 1'b0, 7458);
        push(1'b1, 1'b1, 14914);
        push(1'b1, 1'b0, 22372);
        push(1'b1, 1'b1, 37282);
        wr_en   = 1'b1;
        wr_data = 2'b10;
        tick();
        wr_en = 1'b0;
        check("t3_mode",    32'(mode),      32'd1);
        check("t3_wr_cnt",  32'(cycle_cnt), 32'd101);
        tick();
        tick();
        check("t3_pend_cnt", 32'(cycle_cnt), 32'd103);
        tick();
        check("t3_restart_cnt", 32'(cycle_cnt), 32'd0);
        wait_cnt(29832);
        check("t3_no_irq", 32'(frame_irq), 32'd0);
        wait_cnt(37282);
        tick();
        check("t3_wrap", 32'(cycle_cnt), 32'd0);

        // Back-to-back writes: only the second one restarts
        push(1'b1, 1'b1, 0);
        wr_en   = 1'b1;
        wr_data = 2'b10;
        tick();
        wr_en = 1'b0;
        tick();
        wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        tick();
        tick();
        check("t5_no_early_restart", 32'(cycle_cnt), 32'd5);
        tick();
        check("t5_restart", 32'(cycle_cnt), 32'd0);
        repeat (30) tick();
        check("t5_single_restart", 32'(cycle_cnt), 32'd30);

        // Sparse enables, reset while a write is pending
        cpu_ce  = 1'b0;
        wr_en   = 1'b1;
        wr_data = 2'b10;
        tick();
        wr_en = 1'b0;
        ce_tick();
        check("t6_pend_cnt", 32'(cycle_cnt), 32'd31);
        rst_l = 1'b0;
        tick();
        check("t6_rst_cnt",  32'(cycle_cnt),     32'd0);
        check("t6_rst_mode", 32'(mode),          32'd0);
        check("t6_rst_irq",  32'(frame_irq),     32'd0);
        check("t6_rst_q",    32'(quarter_frame), 32'd0);
        check("t6_rst_h",    32'(half_frame),    32'd0);
        rst_l = 1'b1;
        repeat (8) ce_tick();
        check("t6_cnt_after", 32'(cycle_cnt), 32'd8);
        check("t6_mode_after", 32'(mode),     32'd0);

        repeat (3) tick();
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
